// File: rtl/msrv32_ahb_arbiter.sv
// Two-requester AHB-Lite master arbiter: fetch and load/store share one port.
// Data has fixed priority; a starvation counter forces a fetch through.
module msrv32_ahb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic [31:0] i_rdata_out,
  output logic        i_ready_out,
  output logic        i_err_out,
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic        d_ready_out,
  output logic        d_err_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        own_d_q, own_d_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        i_err_q, i_err_d;
  logic        d_err_q, d_err_d;

  logic [2:0]  d_size;
  logic [1:0]  d_off;
  logic        grant_i;

  always_comb begin
    d_size = 3'b010;
    d_off  = 2'b00;
    case (d_mask_in)
      4'b0011: d_size = 3'b001;
      4'b1100: begin d_size = 3'b001; d_off = 2'd2; end
      4'b0001: begin d_size = 3'b000; d_off = 2'd0; end
      4'b0010: begin d_size = 3'b000; d_off = 2'd1; end
      4'b0100: begin d_size = 3'b000; d_off = 2'd2; end
      4'b1000: begin d_size = 3'b000; d_off = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    own_d_d   = own_d_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    hwdata_d  = hwdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_err_d   = i_err_q;
    d_err_d   = d_err_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    grant_i   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_in || d_req_in) begin
          grant_i  = i_req_in && (!d_req_in || starve_q == LIMIT);
          own_d_d  = !grant_i;
          htrans_d = HT_NONSEQ;
          state_d  = ADDR;
          if (grant_i) begin
            haddr_d  = {i_addr_in[31:2], 2'b00};
            hwrite_d = 1'b0;
            hsize_d  = 3'b010;
            starve_d = 4'd0;
          end else begin
            haddr_d  = {d_addr_in[31:2], d_off};
            hwrite_d = d_we_in;
            hsize_d  = d_size;
            if (d_we_in) hwdata_d = d_wdata_in;
            if (i_req_in && starve_q < LIMIT)
              starve_d = starve_q + 4'd1;
          end
        end
      end
      ADDR: begin
        if (hready_in) begin
          htrans_d = HT_IDLE;
          state_d  = DATA;
        end
      end
      DATA: begin
        // An ERROR with HREADY low is just a wait state; sample on HREADY.
        if (hready_in) begin
          state_d = RESP;
          if (own_d_q) begin
            d_rdata_d = hrdata_in;
            d_err_d   = hresp_in;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = hrdata_in;
            i_err_d   = hresp_in;
            i_ready_d = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      own_d_q   <= 1'b0;
      haddr_q   <= 32'd0;
      htrans_q  <= HT_IDLE;
      hwrite_q  <= 1'b0;
      hsize_q   <= 3'b010;
      hwdata_q  <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      own_d_q   <= own_d_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      hwdata_q  <= hwdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  assign haddr_out   = haddr_q;
  assign htrans_out  = htrans_q;
  assign hwrite_out  = hwrite_q;
  assign hsize_out   = hsize_q;
  assign hwdata_out  = hwdata_q;
  assign i_rdata_out = i_rdata_q;
  assign d_rdata_out = d_rdata_q;
  assign i_ready_out = i_ready_q;
  assign d_ready_out = d_ready_q;
  assign i_err_out   = i_err_q;
  assign d_err_out   = d_err_q;

endmodule

// File: tb/tb_msrv32_ahb_arbiter.sv
// Bench for msrv32_ahb_arbiter: vector table, hand sequences, random traffic
// checked against a transaction-level arbitration model.
module tb_msrv32_ahb_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_in, d_req_in, d_we_in;
  logic [31:0] i_addr_in, d_addr_in, d_wdata_in;
  logic [3:0]  d_mask_in;
  logic [31:0] i_rdata_out, d_rdata_out;
  logic        i_ready_out, i_err_out, d_ready_out, d_err_out;
  logic [31:0] haddr_out, hwdata_out, hrdata_in;
  logic [1:0]  htrans_out;
  logic        hwrite_out, hready_in, hresp_in;
  logic [2:0]  hsize_out;

  msrv32_ahb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .i_req_in(i_req_in),
    .i_addr_in(i_addr_in),
    .i_rdata_out(i_rdata_out),
    .i_ready_out(i_ready_out),
    .i_err_out(i_err_out),
    .d_req_in(d_req_in),
    .d_we_in(d_we_in),
    .d_addr_in(d_addr_in),
    .d_wdata_in(d_wdata_in),
    .d_mask_in(d_mask_in),
    .d_rdata_out(d_rdata_out),
    .d_ready_out(d_ready_out),
    .d_err_out(d_err_out),
    .haddr_out(haddr_out),
    .htrans_out(htrans_out),
    .hwrite_out(hwrite_out),
    .hsize_out(hsize_out),
    .hwdata_out(hwdata_out),
    .hrdata_in(hrdata_in),
    .hready_in(hready_in),
    .hresp_in(hresp_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_starve;
  logic [31:0] m_hw;

  // observations of the last transfer
  bit          obs_ok;
  logic [31:0] obs_addr, obs_hwdata;
  logic        obs_write;
  logic [2:0]  obs_size;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic void data_map(input logic [3:0] m,
                                   output logic [2:0] sz,
                                   output logic [1:0] off);
    sz = 3'd2;
    off = 2'd0;
    if (m == 4'b0011) sz = 3'd1;
    else if (m == 4'b1100) begin sz = 3'd1; off = 2'd2; end
    else if ($countones(m) == 1) begin
      sz = 3'd0;
      off = 2'($clog2(m));
    end
  endfunction

  // Drives the slave side for one transfer; leaves us at the RESP negedge.
  task automatic run_xfer(input int aw, input int dw, input bit er,
                          input logic [31:0] rd, input string tag);
    bit seen = 0;
    obs_ok = 0;
    hready_in = 1'b1;
    hresp_in = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (htrans_out == 2'b10) seen = 1;
      else chk({tag, "_idle_noready"}, 32'({i_ready_out, d_ready_out}), 32'd0);
    end
    chk({tag, "_nonseq_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    obs_addr = haddr_out;
    obs_write = hwrite_out;
    obs_size = hsize_out;
    for (int k = 0; k < aw; k++) begin
      hready_in = 1'b0;
      @(negedge clk);
      chk({tag, "_aw_trans"}, 32'(htrans_out), 32'd2);
      chk({tag, "_aw_addr"}, haddr_out, obs_addr);
    end
    hready_in = 1'b1;
    @(negedge clk);
    chk({tag, "_data_trans"}, 32'(htrans_out), 32'd0);
    obs_hwdata = hwdata_out;
    for (int k = 0; k < dw; k++) begin
      hready_in = 1'b0;
      hresp_in = er;
      hrdata_in = $urandom;
      @(negedge clk);
      chk({tag, "_dw_noready"}, 32'({i_ready_out, d_ready_out}), 32'd0);
      chk({tag, "_dw_addr"}, haddr_out, obs_addr);
      chk({tag, "_dw_hwdata"}, hwdata_out, obs_hwdata);
    end
    hready_in = 1'b1;
    hresp_in = er;
    hrdata_in = rd;
    @(negedge clk);
    hresp_in = 1'b0;
    hrdata_in = 32'd0;
    obs_ok = 1;
  endtask

  // Predicts the grant from the currently driven requests, runs it, checks.
  task automatic model_xfer(input string tag, input int aw, input int dw,
                            input bit er, input logic [31:0] rd,
                            input bit keep, output bit gd);
    logic [31:0] xa, xhw;
    logic [2:0]  xs;
    logic [1:0]  off;
    logic        xw;
    bit gi;
    gi = i_req_in && (!d_req_in || m_starve == LIM);
    gd = !gi;
    if (gi) begin
      m_starve = 0;
      xa = {i_addr_in[31:2], 2'b00};
      xs = 3'd2;
      xw = 1'b0;
    end else begin
      if (i_req_in && m_starve < LIM) m_starve++;
      data_map(d_mask_in, xs, off);
      xa = {d_addr_in[31:2], off};
      xw = d_we_in;
      if (d_we_in) m_hw = d_wdata_in;
    end
    xhw = m_hw;
    run_xfer(aw, dw, er, rd, tag);
    if (!obs_ok) return;
    chk({tag, "_i_ready"}, 32'(i_ready_out), 32'(gi));
    chk({tag, "_d_ready"}, 32'(d_ready_out), 32'(gd));
    chk({tag, "_haddr"}, obs_addr, xa);
    chk({tag, "_hsize"}, 32'(obs_size), 32'(xs));
    chk({tag, "_hwrite"}, 32'(obs_write), 32'(xw));
    chk({tag, "_hwdata"}, obs_hwdata, xhw);
    chk({tag, "_rdata"}, gi ? i_rdata_out : d_rdata_out, rd);
    chk({tag, "_err"}, 32'(gi ? i_err_out : d_err_out), 32'(er));
    if (!keep) begin
      if (gi) i_req_in = 1'b0;
      else d_req_in = 1'b0;
    end
  endtask

  typedef struct {
    bit          ir, dr, we;
    logic [31:0] ia, da, wd, rd;
    logic [3:0]  m;
    int          aw, dw;
    bit          er;
    bit          xd;
    logic [31:0] xa;
    logic [2:0]  xs;
  } vec_t;

  vec_t vt[11];
  bit   pat[10];
  bit   gd;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1,0,0, 32'h0000_0104, 0, 0, 32'h0000_0013, 4'hF, 0,0,0, 0, 32'h0000_0104, 3'd2};
    vt[1]  = '{0,1,1, 0, 32'h2000_0000, 32'h00AB_0000, 32'h0, 4'b0100, 0,0,0, 1, 32'h2000_0002, 3'd0};
    vt[2]  = '{0,1,0, 0, 32'h1000_0010, 0, 32'hDEAD_BEEF, 4'b1100, 1,0,0, 1, 32'h1000_0012, 3'd1};
    vt[3]  = '{0,1,0, 0, 32'h3000_0008, 0, 32'hCAFE_0001, 4'hF, 0,3,0, 1, 32'h3000_0008, 3'd2};
    vt[4]  = '{0,1,0, 0, 32'hFFFF_FFF0, 0, 32'h0BAD_0BAD, 4'hF, 0,1,1, 1, 32'hFFFF_FFF0, 3'd2};
    vt[5]  = '{0,1,0, 0, 32'h0000_0040, 0, 32'h0000_0055, 4'b0001, 0,0,0, 1, 32'h0000_0040, 3'd0};
    vt[6]  = '{1,0,0, 32'h0000_0207, 0, 0, 32'h1234_0000, 4'hF, 0,0,0, 0, 32'h0000_0204, 3'd2};
    vt[7]  = '{0,1,1, 0, 32'h0000_0102, 32'h1234_5678, 32'h0, 4'b0000, 0,0,0, 1, 32'h0000_0100, 3'd2};
    vt[8]  = '{0,1,0, 0, 32'h0000_0203, 0, 32'h7777_7777, 4'b0101, 2,2,0, 1, 32'h0000_0200, 3'd2};
    vt[9]  = '{0,1,1, 0, 32'h0000_0500, 32'hEF00_0000, 32'h0, 4'b1000, 0,0,0, 1, 32'h0000_0503, 3'd0};
    vt[10] = '{1,0,0, 32'h0000_8000, 0, 0, 32'h0000_0001, 4'hF, 2,1,1, 0, 32'h0000_8000, 3'd2};
    pat = '{1,1,1,1,0,1,1,1,1,0};

    rst = 1'b1;
    i_req_in = 0; d_req_in = 0; d_we_in = 0;
    i_addr_in = 0; d_addr_in = 0; d_wdata_in = 0; d_mask_in = 4'hF;
    hrdata_in = 0; hready_in = 1; hresp_in = 0;
    m_starve = 0;
    m_hw = 0;
    repeat (2) @(negedge clk);
    chk("rst_htrans", 32'(htrans_out), 32'd0);
    chk("rst_haddr", haddr_out, 32'd0);
    chk("rst_hwrite", 32'(hwrite_out), 32'd0);
    chk("rst_hsize", 32'(hsize_out), 32'd2);
    chk("rst_hwdata", hwdata_out, 32'd0);
    chk("rst_rdata", i_rdata_out | d_rdata_out, 32'd0);
    chk("rst_ready", 32'({i_ready_out, d_ready_out}), 32'd0);
    chk("rst_err", 32'({i_err_out, d_err_out}), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      i_req_in = vt[v].ir; i_addr_in = vt[v].ia;
      d_req_in = vt[v].dr; d_we_in = vt[v].we; d_addr_in = vt[v].da;
      d_wdata_in = vt[v].wd; d_mask_in = vt[v].m;
      model_xfer($sformatf("vec%0d", v), vt[v].aw, vt[v].dw, vt[v].er,
                 vt[v].rd, 0, gd);
      chk($sformatf("vec%0d_owner", v), 32'(gd), 32'(vt[v].xd));
      chk($sformatf("vec%0d_addr_tab", v), obs_addr, vt[v].xa);
      chk($sformatf("vec%0d_size_tab", v), 32'(obs_size), 32'(vt[v].xs));
    end

    // both requesting continuously: D,D,D,D,I,D,D,D,D,I
    i_req_in = 1; i_addr_in = 32'h0000_1000;
    d_req_in = 1; d_we_in = 0; d_addr_in = 32'h0000_2000; d_mask_in = 4'hF;
    for (int n = 0; n < 10; n++) begin
      model_xfer($sformatf("starve%0d", n), 0, 0, 0, $urandom, 1, gd);
      chk($sformatf("starve%0d_order", n), 32'(gd), 32'(pat[n]));
    end

    // two data grants, then reset in the DATA phase of the third
    for (int n = 0; n < 2; n++)
      model_xfer($sformatf("pre%0d", n), 0, 0, 0, $urandom, 1, gd);
    begin
      bit seen = 0;
      for (int t = 0; t < 8 && !seen; t++) begin
        @(negedge clk);
        if (htrans_out == 2'b10) seen = 1;
      end
      chk("rstdata_nonseq_seen", 32'(seen), 32'd1);
    end
    @(negedge clk);
    chk("rstdata_in_data", 32'(htrans_out), 32'd0);
    hready_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstdata_htrans", 32'(htrans_out), 32'd0);
    chk("rstdata_ready", 32'({i_ready_out, d_ready_out}), 32'd0);
    chk("rstdata_haddr", haddr_out, 32'd0);
    @(negedge clk);
    chk("rstdata_held_ready", 32'({i_ready_out, d_ready_out}), 32'd0);
    rst = 1'b0;
    hready_in = 1'b1;
    m_starve = 0;
    m_hw = 0;
    for (int n = 0; n < 5; n++) begin
      model_xfer($sformatf("post%0d", n), 0, 0, 0, $urandom, 1, gd);
      chk($sformatf("post%0d_order", n), 32'(gd), 32'(pat[n]));
    end
    i_req_in = 0;
    d_req_in = 0;

    // randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      if (!i_req_in && $urandom_range(1, 0) == 1) begin
        i_req_in = 1;
        i_addr_in = $urandom;
      end
      if (!d_req_in && (!i_req_in || $urandom_range(1, 0) == 1)) begin
        d_req_in = 1;
        d_we_in = 1'($urandom_range(1, 0));
        d_addr_in = $urandom;
        d_wdata_in = $urandom;
        case ($urandom_range(7, 0))
          0: d_mask_in = 4'b1111;
          1: d_mask_in = 4'b0011;
          2: d_mask_in = 4'b1100;
          3: d_mask_in = 4'b0001;
          4: d_mask_in = 4'b0010;
          5: d_mask_in = 4'b0100;
          6: d_mask_in = 4'b1000;
          default: d_mask_in = 4'($urandom_range(15, 0));
        endcase
      end
      model_xfer($sformatf("rnd%0d", n), int'($urandom_range(2, 0)),
                 int'($urandom_range(2, 0)), $urandom_range(7, 0) == 0,
                 $urandom, 0, gd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
